div_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one 32-bit multi-cycle divider (start/A/B in, D/R/ok/err out) between N_REQ requesters.
- Accepts one request at a time and drives divider operands plus a one-cycle start pulse.
- Waits for completion, then returns quotient, remainder and error flag to the winning requester, tagged with its index.
- Sits between the compute clients and the divider instance in the accelerator datapath.

---
 rtl/div_arb_pkg.sv | 18 +
 rtl/div_arbiter_rr_arbiter.sv | 37 +++
 rtl/div_arbiter.sv | 173 +++++++++++++++++
 tb/tb_div_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned DIV_WIDTH = 32;

  // Index width for a given requester count; at least one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts at ptr and the first valid index wins.
module div_arbiter_rr_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]              req,
  input  logic [id_width(N_REQ)-1:0]    ptr,
  output logic [N_REQ-1:0]              grant,
  output logic [id_width(N_REQ)-1:0]    idx
);

  localparam int unsigned IdW = id_width(N_REQ);

  logic           found;
  logic [IdW-1:0] cand;
  int unsigned    pos;

  // Rotating priority search; ptr is always kept below N_REQ.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    pos   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos  = (32'(ptr) + i) % N_REQ;
      cand = IdW'(pos);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sequencer sharing one multi-cycle divider between N_REQ requesters.
// Optional watchdog in WAIT enabled by defining DIV_ARB_TIMEOUT_EN.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned WIDTH          = DIV_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*WIDTH-1:0]      req_a,
  input  logic [N_REQ*WIDTH-1:0]      req_b,
  output logic                        rsp_valid,
  output logic [id_width(N_REQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]            rsp_d,
  output logic [WIDTH-1:0]            rsp_r,
  output logic                        rsp_err,
  output logic                        busy,
  output logic                        div_start,
  output logic [WIDTH-1:0]            div_a,
  output logic [WIDTH-1:0]            div_b,
  input  logic [WIDTH-1:0]            div_d,
  input  logic [WIDTH-1:0]            div_r,
  input  logic                        div_ok,
  input  logic                        div_err
);

  localparam int unsigned IdW = id_width(N_REQ);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("div_arbiter: N_REQ must be 2..16");
  end
  if (WIDTH != DIV_WIDTH) begin : g_bad_width
    $error("div_arbiter: WIDTH must match the divider width");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("div_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_e           state_q, state_d;
  logic [IdW-1:0]   rr_q, rr_next;
  logic [IdW-1:0]   id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IdW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_d_q, rsp_r_q;
  logic             rsp_err_q;

  logic [N_REQ-1:0] grant;
  logic [IdW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             hs;
  logic             done;
  logic             timeout;

  div_arbiter_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_q),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign hs      = (state_q == StIdle) && (|grant);
  assign done    = div_ok | div_err;
  assign rr_next = (gnt_idx == IdW'(N_REQ - 1)) ? '0 : gnt_idx + IdW'(1);

  // Operand mux driven directly by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  // Watchdog counts WAIT cycles; it is zero on WAIT entry since ISSUE clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == StWait) begin
      cnt_q <= cnt_q + CntW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // A completion on the limit cycle still wins over the timeout.
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES)) && !done;
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (done || timeout) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: operand/id capture on grant, result capture on completion or timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q      <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_id_q  <= '0;
      rsp_d_q   <= '0;
      rsp_r_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (hs) begin
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= gnt_idx;
        rr_q <= rr_next;
      end
      if (state_q == StWait) begin
        if (done) begin
          rsp_id_q  <= id_q;
          rsp_d_q   <= div_d;
          rsp_r_q   <= div_r;
          rsp_err_q <= div_err;
        end else if (timeout) begin
          rsp_id_q  <= id_q;
          rsp_d_q   <= '0;
          rsp_r_q   <= '0;
          rsp_err_q <= 1'b1;
        end
      end
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    req_ready = (state_q == StIdle) ? grant : '0;
    busy      = (state_q != StIdle);
    div_start = (state_q == StIssue);
    rsp_valid = (state_q == StResp);
    div_a     = a_q;
    div_b     = b_q;
    rsp_id    = rsp_id_q;
    rsp_d     = rsp_d_q;
    rsp_r     = rsp_r_q;
    rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural divider model.
module tb_div_arbiter;

  localparam int N = 4;
  localparam int W = 32;
`ifdef DIV_ARB_TIMEOUT_EN
  localparam int LONG_LAT = 12;
`else
  localparam int LONG_LAT = 34;
`endif

  typedef struct {
    int          id;
    logic [31:0] d;
    logic [31:0] r;
    logic        err;
    logic        to;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_d, rsp_r;
  logic           rsp_err, busy, div_start;
  logic [W-1:0]   div_a, div_b, div_d, div_r;
  logic           div_ok, div_err;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rsp_seen = 0;
  int   hs_cyc = 0;
  int   start_cyc = 0;
  exp_t exp_q[$];
  int   done_q[$];

  // Divider model controls: mode 0 normal, 1 ok+err together, 2 never completes.
  int          lat = 4;
  int          mode = 0;
  logic        spur = 1'b0;
  logic        m_ok, m_err, m_act;
  logic [31:0] m_d, m_r, m_a, m_b;
  int          m_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_arbiter #(
    .N_REQ          (N),
    .WIDTH          (W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_d     (rsp_d),
    .rsp_r     (rsp_r),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_d     (div_d),
    .div_r     (div_r),
    .div_ok    (div_ok),
    .div_err   (div_err)
  );

  assign div_ok  = m_ok | spur;
  assign div_err = m_err;
  assign div_d   = m_d;
  assign div_r   = m_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Divider: done pulses in cycle start+lat.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act <= 1'b0; m_cnt <= 0; m_ok <= 1'b0; m_err <= 1'b0;
      m_d <= '0; m_r <= '0; m_a <= '0; m_b <= '0;
    end else begin
      m_ok  <= 1'b0;
      m_err <= 1'b0;
      if (div_start) begin
        m_act <= 1'b1; m_cnt <= 1; m_a <= div_a; m_b <= div_b;
      end else if (m_act) begin
        m_cnt <= m_cnt + 1;
        if (mode != 2 && m_cnt == lat - 1) begin
          m_act <= 1'b0;
          done_q.push_back(cyc + 1);
          if (m_b == 0) begin
            m_err <= 1'b1; m_d <= '1; m_r <= m_a;
          end else begin
            m_ok <= 1'b1; m_err <= (mode == 1); m_d <= m_a / m_b; m_r <= m_a % m_b;
          end
        end
      end
    end
  end

  // Monitor: timing of start, operand stability, and response scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (|(req_valid & req_ready)) hs_cyc = cyc;
        if (div_start) begin
          chk("start_lat", 64'(cyc), 64'(hs_cyc + 1));
          start_cyc = cyc;
        end else if (m_act) begin
          chk("div_a_hold", {div_a, div_b}, {m_a, m_b});
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_d", 64'(rsp_d), 64'(e.d));
            chk("rsp_r", 64'(rsp_r), 64'(e.r));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            if (e.to) chk("timeout_lat", 64'(cyc), 64'(start_cyc + 18));
            else if (done_q.size() != 0) chk("rsp_lat", 64'(cyc), 64'(done_q.pop_front() + 1));
            else chk("rsp_lat_missing", 64'(0), 64'(1));
          end
          rsp_seen++;
        end
      end
    end
  end

  task automatic expect_rsp(input int id, input logic [31:0] d, input logic [31:0] r,
                            input logic err, input logic to);
    exp_t e;
    e.id = id; e.d = d; e.r = r; e.err = err; e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic send_one(input int id, input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    @(posedge clk); #1;
    req_valid[id] = 1'b1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
    end
    if (!ok) chk("grant_wait", 64'(0), 64'(1));
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    bit got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(posedge clk);
      if (rsp_seen >= n) got = 1'b1;
    end
    if (!got) chk("wait_rsp", 64'(rsp_seen), 64'(n));
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    done_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int base;
    #12;
    chk("rst_ctrl", {req_ready, rsp_valid, busy, div_start, rsp_err}, '0);
    chk("rst_div_ab", {div_a, div_b}, '0);
    chk("rst_rsp_dr", {rsp_d, rsp_r}, '0);
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Single request, long divider latency.
    lat = LONG_LAT;
    base = rsp_seen;
    expect_rsp(2, 14, 2, 1'b0, 1'b0);
    send_one(2, 100, 7);
    wait_rsp(base + 1);

    // Fairness from a fresh pointer with all requesters valid.
    do_reset();
    lat = 4;
    base = rsp_seen;
    for (int i = 0; i < N; i++) expect_rsp(i, 100, i, 1'b0, 1'b0);
    expect_rsp(0, 100, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 1000 + i;
      req_b[i*W +: W] = 10;
    end
    req_valid = '1;
    @(negedge clk);
    chk("rr_first_grant", 64'(req_ready), 64'(4'b0001));
    wait_rsp(base + 5);
    #1 req_valid = '0;

    // Divide by zero, then a normal transaction.
    base = rsp_seen;
    expect_rsp(1, 32'hFFFF_FFFF, 77, 1'b1, 1'b0);
    send_one(1, 77, 0);
    wait_rsp(base + 1);
    expect_rsp(3, 10, 0, 1'b0, 1'b0);
    send_one(3, 50, 5);
    wait_rsp(base + 2);

    // ok and err together: err wins, data still captured.
    mode = 1;
    base = rsp_seen;
    expect_rsp(2, 7, 3, 1'b1, 1'b0);
    send_one(2, 45, 6);
    wait_rsp(base + 1);
    mode = 0;

    // Spurious done while idle must be ignored.
    #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("spur_idle", {rsp_valid, busy}, '0);
    end

    // Reset while waiting: no response, pointer back to 0.
    lat = 100;
    send_one(1, 500, 3);
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("reset_wait", {busy, rsp_valid, div_start}, '0);
    done_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    lat = 3;
    base = rsp_seen;
    expect_rsp(0, 3, 1, 1'b0, 1'b0);
    expect_rsp(2, 9, 0, 1'b0, 1'b0);
    req_a[0*W +: W] = 7;  req_b[0*W +: W] = 2;
    req_a[2*W +: W] = 81; req_b[2*W +: W] = 9;
    req_valid = 4'b0101;
    @(negedge clk);
    chk("rr_after_reset", 64'(req_ready), 64'(4'b0001));
    wait_rsp(base + 2);
    #1 req_valid = '0;

`ifdef DIV_ARB_TIMEOUT_EN
    // Divider never completes: watchdog response.
    mode = 2;
    base = rsp_seen;
    expect_rsp(0, 0, 0, 1'b1, 1'b1);
    send_one(0, 9, 3);
    wait_rsp(base + 1);
    mode = 0;
`endif

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
